ndsum_update: RTL and testbench
===============================

// Module: ndsum_update
// PURPOSE
//  Read-modify-write engine for the per-document topic-count BRAM (ndsum) in the LDA Gibbs sampler.
//  Accepts one count update per cycle: increment or decrement the count of document i_doc.
//  Drives the BRAM write port and read address, and consumes its 1-cycle read data.
//  Forwards in-flight results so back-to-back updates to one document are exact.
//  Zeroes the whole table after reset and reports old/new counts downstream to the sampler.
// PARAMETERS
//  WORDSIZE  32    count width; matches the ndsum BRAM data width
//  ADDRSIZE  32    document address width; matches the ndsum BRAM address width
//  NUM_DOCS  1024  number of table entries cleared at init; docs >= NUM_DOCS are illegal
// PORTS
//  clk          in   1         single clock; all logic on the rising edge
//  rst          in   1         synchronous, active-high reset
//  i_valid      in   1         update request valid
//  o_ready      out  1         ready for a request; a request is accepted when i_valid && o_ready
//  i_doc        in   ADDRSIZE  document index
//  i_dec        in   1         1 = decrement, 0 = increment
//  o_raddr      out  ADDRSIZE  to BRAM read address (addrb)
//  i_rdata      in   WORDSIZE  from BRAM read data (doutb); valid 1 cycle after o_raddr
//  o_wen        out  1         to BRAM write enable (wea)
//  o_waddr      out  ADDRSIZE  to BRAM write address (addra)
//  o_wdata      out  WORDSIZE  to BRAM write data (dina)
//  o_valid      out  1         1-cycle strobe: an update has been committed
//  o_doc        out  ADDRSIZE  document of the committed update
//  o_old        out  WORDSIZE  count before the update
//  o_new        out  WORDSIZE  count after the update
//  o_init_done  out  1         table clear complete
//  o_uflow      out  1         sticky: decrement was attempted at 0
//  o_oflow      out  1         sticky: increment was attempted at all-ones
//  o_range_err  out  1         sticky: request had i_doc >= NUM_DOCS
// BEHAVIOUR
//  Reset:
//   - state = INIT and init counter = 0; pipeline valids are cleared.
//   - All outputs are 0, including o_ready.
//   - Reset asserted mid-operation drops in-flight updates (no write, no o_valid) and restarts INIT.
//  FSM INIT:
//   - Each cycle: o_wen = 1, o_waddr = cnt, o_wdata = 0, then cnt++.
//   - After address NUM_DOCS-1 is written, go to RUN on the next cycle.
//   - o_ready = 0 throughout INIT.
//  FSM RUN:
//   - o_ready = 1 and o_init_done = 1; there is no backpressure, so one update is accepted per cycle.
//   - RUN has no exit other than rst.
//  Pipeline (request accepted in cycle t):
//   - t:   o_raddr = i_doc (combinational); register S1 <= {doc, dec}.
//   - t+1: old = i_rdata, subject to the forwarding rules below; new = old +/- 1; register S2.
//   - t+2: o_wen = 1, o_waddr/o_wdata = S2 doc/new; o_valid = 1 with o_doc/o_old/o_new.
//   - Latency is 2 cycles from accept to commit; throughput is 1 per cycle.
//  Forwarding, evaluated at S1 in priority order:
//   1. S2 is valid and S2.doc == S1.doc: old = S2.new. S2's write lands in this same cycle, so BRAM data is stale.
//   2. S3 is valid and S3.doc == S1.doc: old = S3.new. S3 is a 1-deep copy of the last commit; its write collided with this read.
//   3. Otherwise old = i_rdata.
//   - The result never depends on BRAM read-first/write-first collision mode.
//  Arithmetic:
//   - Unsigned, WORDSIZE bits, saturating.
//   - Decrement at 0: new = 0 and o_uflow is set.
//   - Increment at {WORDSIZE{1'b1}}: new is held at that value and o_oflow is set.
//   - A saturated update still commits (write and o_valid both occur).
//  Range check:
//   - A request with i_doc >= NUM_DOCS is accepted and discarded.
//   - It produces no write and no o_valid; it sets o_range_err.
//   - It does not occupy a forwarding slot.
//  o_raddr while idle: holds its last value; it is don't-care.
// STRUCTURE
//  Shared package ndsum_pkg:
//   - FSM state encoding: ST_INIT, ST_RUN.
//   - Localparam RD_LAT = 1 for the BRAM read latency.
//  Sub-module ndsum_sat_addsub: combinational saturating +/-1 that also flags uflow/oflow.
//  FSM, init counter, S1/S2/S3 registers and forwarding muxes stay in this module.
//  Connects to the ndsum BRAM wrapper as its wen/waddr/wdata/raddr master.
// TESTING
//  1. Reset, then NUM_DOCS=8 -> o_wen for 8 cycles on addrs 0..7 with data 0; o_ready rises on cycle 9; o_init_done = 1.
//  2. inc doc 3, then idle 4 cycles, then inc doc 3 -> commits (old 0, new 1) then (1, 2); BRAM[3] = 2.
//  3. Back-to-back inc doc 5 x4 in consecutive cycles -> o_new sequence 1, 2, 3, 4 (S2 forwarding); BRAM[5] = 4.
//  4. inc doc 2, inc doc 7, inc doc 2 in consecutive cycles -> third commit has old = 1 via S3 forwarding.
//  5. dec doc 0 at count 0 -> new = 0, o_uflow = 1.
//  6. Preload count all-ones, then inc -> new = all-ones, o_oflow = 1.
//  7. Assert rst with 2 updates in flight -> no o_valid for them; INIT repeats and all entries read back 0.
//  8. Request with i_doc = NUM_DOCS -> no o_wen, no o_valid; o_range_err = 1.

Source files
------------

// File: rtl/ndsum_pkg.sv
// Shared types for the ndsum read-modify-write engine.
// Holds the FSM state encoding and the BRAM read latency.
package ndsum_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/ndsum_sat_addsub.sv
// Saturating +/-1 on an unsigned count, with underflow/overflow flags.
// Ports: a (count in), dec (1=decrement), y (result), uflow, oflow.
module ndsum_sat_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         dec,
  output logic [W-1:0] y,
  output logic         uflow,
  output logic         oflow
);

  always_comb begin
    uflow = dec && (a == '0);
    oflow = !dec && (a == '1);
    if (uflow || oflow)
      y = a;
    else if (dec)
      y = a - W'(1);
    else
      y = a + W'(1);
  end

endmodule

// File: rtl/ndsum_update.sv
// Read-modify-write engine for the per-document count BRAM (ndsum).
// Ports: update request (i_valid/o_ready/i_doc/i_dec), BRAM master
// (o_raddr/i_rdata/o_wen/o_waddr/o_wdata), commit report
// (o_valid/o_doc/o_old/o_new), status (o_init_done, sticky error flags).
module ndsum_update
  import ndsum_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int ADDRSIZE = 32,
  parameter int NUM_DOCS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [ADDRSIZE-1:0] i_doc,
  input  logic                i_dec,
  output logic [ADDRSIZE-1:0] o_raddr,
  input  logic [WORDSIZE-1:0] i_rdata,
  output logic                o_wen,
  output logic [ADDRSIZE-1:0] o_waddr,
  output logic [WORDSIZE-1:0] o_wdata,
  output logic                o_valid,
  output logic [ADDRSIZE-1:0] o_doc,
  output logic [WORDSIZE-1:0] o_old,
  output logic [WORDSIZE-1:0] o_new,
  output logic                o_init_done,
  output logic                o_uflow,
  output logic                o_oflow,
  output logic                o_range_err
);

  localparam logic [ADDRSIZE-1:0] LAST = ADDRSIZE'(NUM_DOCS - 1);
  localparam logic [ADDRSIZE-1:0] LIM  = ADDRSIZE'(NUM_DOCS);

  state_t state, state_nx;
  logic [ADDRSIZE-1:0] cnt;
  logic [ADDRSIZE-1:0] raddr_q;

  logic                s1_v, s1_dec;
  logic [ADDRSIZE-1:0] s1_doc;
  logic                s2_v;
  logic [ADDRSIZE-1:0] s2_doc;
  logic [WORDSIZE-1:0] s2_old, s2_new;
  logic                s3_v;
  logic [ADDRSIZE-1:0] s3_doc;
  logic [WORDSIZE-1:0] s3_new;

  logic                uflow_q, oflow_q, rerr_q;

  logic                live, run, accept, in_range;
  logic                fwd2, fwd3;
  logic [WORDSIZE-1:0] old_v, new_v;
  logic                uf, of;

  // Every output is forced low while rst is held, so an update
  // caught in S2 when reset arrives never reaches the BRAM.
  assign live     = !rst;
  assign run      = live && (state == ST_RUN);
  assign accept   = i_valid && run;
  assign in_range = i_doc < LIM;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT: if (cnt == LAST) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  // S2 is writing this cycle, so the BRAM word is stale; S3 wrote
  // last cycle and collided with our read. S2 is the newer value.
  assign fwd2 = s2_v && (s2_doc == s1_doc);
  assign fwd3 = !fwd2 && s3_v && (s3_doc == s1_doc);

  always_comb begin
    old_v = i_rdata;
    unique case (1'b1)
      fwd2:    old_v = s2_new;
      fwd3:    old_v = s3_new;
      default: old_v = i_rdata;
    endcase
  end

  ndsum_sat_addsub #(
    .W(WORDSIZE)
  ) u_sat (
    .a    (old_v),
    .dec  (s1_dec),
    .y    (new_v),
    .uflow(uf),
    .oflow(of)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      raddr_q <= '0;
      s1_v    <= 1'b0;
      s1_dec  <= 1'b0;
      s1_doc  <= '0;
      s2_v    <= 1'b0;
      s2_doc  <= '0;
      s2_old  <= '0;
      s2_new  <= '0;
      s3_v    <= 1'b0;
      s3_doc  <= '0;
      s3_new  <= '0;
      uflow_q <= 1'b0;
      oflow_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      if (state == ST_INIT) cnt <= cnt + ADDRSIZE'(1);
      if (accept) begin
        raddr_q <= i_doc;
        s1_doc  <= i_doc;
        s1_dec  <= i_dec;
      end
      // Out-of-range requests never enter the pipeline.
      s1_v <= accept && in_range;
      s2_v <= s1_v;
      if (s1_v) begin
        s2_doc <= s1_doc;
        s2_old <= old_v;
        s2_new <= new_v;
      end
      s3_v <= s2_v;
      if (s2_v) begin
        s3_doc <= s2_doc;
        s3_new <= s2_new;
      end
      if (s1_v && uf) uflow_q <= 1'b1;
      if (s1_v && of) oflow_q <= 1'b1;
      if (accept && !in_range) rerr_q <= 1'b1;
    end
  end

  always_comb begin
    o_wen   = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    unique case (1'b1)
      live && (state == ST_INIT): begin
        o_wen   = 1'b1;
        o_waddr = cnt;
      end
      live && s2_v: begin
        o_wen   = 1'b1;
        o_waddr = s2_doc;
        o_wdata = s2_new;
      end
      default: o_wen = 1'b0;
    endcase
  end

  assign o_ready     = run;
  assign o_init_done = run;
  assign o_raddr     = !live  ? '0 :
                       accept ? i_doc : raddr_q;
  assign o_valid     = live && s2_v;
  assign o_doc       = live ? s2_doc : '0;
  assign o_old       = live ? s2_old : '0;
  assign o_new       = live ? s2_new : '0;
  assign o_uflow     = live && uflow_q;
  assign o_oflow     = live && oflow_q;
  assign o_range_err = live && rerr_q;

endmodule

// File: tb/tb_ndsum_update.sv
// Bench for ndsum_update: BRAM model plus a sequential count model.
// Random and directed updates, commits checked against a queue.
module tb_ndsum_update;

  localparam int W = 32;
  localparam int A = 32;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_dec = 1'b0;
  logic [A-1:0] i_doc = '0;
  logic [W-1:0] i_rdata;
  logic         o_ready, o_wen, o_valid;
  logic         o_init_done, o_uflow, o_oflow, o_range_err;
  logic [A-1:0] o_raddr, o_waddr, o_doc;
  logic [W-1:0] o_wdata, o_old, o_new;

  always #5 clk = ~clk;

  ndsum_update #(
    .WORDSIZE(W),
    .ADDRSIZE(A),
    .NUM_DOCS(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_doc      (i_doc),
    .i_dec      (i_dec),
    .o_raddr    (o_raddr),
    .i_rdata    (i_rdata),
    .o_wen      (o_wen),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata),
    .o_valid    (o_valid),
    .o_doc      (o_doc),
    .o_old      (o_old),
    .o_new      (o_new),
    .o_init_done(o_init_done),
    .o_uflow    (o_uflow),
    .o_oflow    (o_oflow),
    .o_range_err(o_range_err)
  );

  // BRAM model, collision mode selectable via wf.
  logic [W-1:0] mem [N];
  bit           wf = 1'b0;
  logic         bd_en = 1'b0;
  logic [2:0]   bd_addr = '0;
  logic [W-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (o_raddr < N) begin
      if (wf && o_wen && o_waddr == o_raddr) i_rdata <= o_wdata;
      else i_rdata <= mem[o_raddr[2:0]];
    end else begin
      i_rdata <= 32'hdead_beef;
    end
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (o_wen && o_waddr < N) mem[o_waddr[2:0]] <= o_wdata;
  end

  typedef struct {
    logic [A-1:0] doc;
    logic [W-1:0] old_v;
    logic [W-1:0] new_v;
    int           cyc;
  } exp_t;

  logic [W-1:0] ref_cnt [N];
  exp_t         q[$];
  bit           exp_uf, exp_of, exp_re;
  int           ncyc = 0;
  bit           init_phase = 1'b0;
  bit           chk_ready = 1'b0;
  int           init_idx = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      chk("rst_quiet", {o_valid, o_wen}, 2'b00);
    end else if (init_phase) begin
      chk("init_wr", {o_wen, o_ready, o_init_done, o_waddr, o_wdata},
          {1'b1, 1'b0, 1'b0, A'(init_idx), W'(0)});
      init_idx++;
      if (init_idx == N) begin
        init_phase = 1'b0;
        chk_ready  = 1'b1;
      end
    end else begin
      if (chk_ready) begin
        chk("ready", {o_ready, o_init_done}, 2'b11);
        chk_ready = 1'b0;
      end
      if (o_wen || o_valid) chk("wen_vs_valid", o_wen, o_valid);
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_commit", o_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("commit_doc", o_doc, e.doc);
          chk("commit_old_new", {o_old, o_new}, {e.old_v, e.new_v});
          chk("commit_wr", {o_waddr, o_wdata}, {e.doc, e.new_v});
          chk("latency", ncyc, e.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= ncyc) begin
        chk("missing_commit", o_valid, 1'b1);
        void'(q.pop_front());
      end
    end
  end

  // Called just after a rising edge; holds the request for one edge.
  task automatic issue(input bit v, input int doc, input bit dec);
    logic [W-1:0] old, nw;
    i_valid = v;
    i_doc   = A'(doc);
    i_dec   = dec;
    if (v) begin
      if (doc >= N) begin
        exp_re = 1'b1;
      end else begin
        old = ref_cnt[doc];
        if (dec) begin
          if (old == 0) begin
            nw = 0;
            exp_uf = 1'b1;
          end else begin
            nw = old - 1;
          end
        end else begin
          if (old == {W{1'b1}}) begin
            nw = old;
            exp_of = 1'b1;
          end else begin
            nw = old + 1;
          end
        end
        ref_cnt[doc] = nw;
        q.push_back('{A'(doc), old, nw, ncyc + 3});
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 0, 1'b0);
  endtask

  task automatic check_flags();
    chk("flags", {o_uflow, o_oflow, o_range_err}, {exp_uf, exp_of, exp_re});
  endtask

  task automatic check_mem();
    for (int i = 0; i < N; i++) chk("mem", mem[i], ref_cnt[i]);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    q.delete();
    exp_uf  = 1'b0;
    exp_of  = 1'b0;
    exp_re  = 1'b0;
    for (int i = 0; i < N; i++) ref_cnt[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {o_ready, o_wen, o_valid, o_init_done, o_uflow,
                       o_oflow, o_range_err, o_doc, o_old, o_new}, '0);
    init_idx   = 0;
    init_phase = 1'b1;
    rst        = 1'b0;
    for (int k = 0; k < N + 10 && (init_phase || chk_ready); k++) begin
      @(posedge clk);
      #1;
    end
    if (init_phase || chk_ready) chk("init_timeout", init_phase, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_mem();

    issue(1, 3, 0);
    idle(4);
    issue(1, 3, 0);
    idle(3);
    chk("bram3", mem[3], 32'd2);

    repeat (4) issue(1, 5, 0);
    idle(3);
    chk("bram5", mem[5], 32'd4);

    issue(1, 2, 0);
    issue(1, 7, 0);
    issue(1, 2, 0);
    idle(3);
    chk("bram2", mem[2], 32'd2);

    issue(1, 0, 1);
    idle(3);
    check_flags();

    bd_en   = 1'b1;
    bd_addr = 3'd4;
    bd_data = '1;
    @(posedge clk);
    #1;
    bd_en = 1'b0;
    ref_cnt[4] = '1;
    issue(1, 4, 0);
    issue(1, 4, 0);
    issue(1, 4, 1);
    idle(3);
    check_flags();

    issue(1, N, 0);
    idle(3);
    check_flags();
    check_mem();

    for (int i = 0; i < 300; i++) begin
      int d;
      wf = (i >= 150);
      d = ($urandom_range(0, 15) == 0) ? N : int'($urandom_range(0, N - 1));
      issue($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1);
    end
    idle(3);
    check_flags();
    check_mem();

    issue(1, 1, 0);
    issue(1, 2, 0);
    do_reset();
    check_mem();
    check_flags();

    issue(1, 6, 0);
    issue(1, 6, 1);
    idle(3);
    check_mem();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
